// File: rtl/cpu_control_unit.sv
// cpu_control_unit: multi-cycle fetch / decode / execute sequencer for the 8-bit CPU.
// Drives the ALU opcode, register-file selects and write strobe, latches ALU flags
// for conditional jumps, and owns the program counter and halt state.
// Optional build macro CPU_SINGLE_STEP_EN: adds input step_req; the FSM parks in IDLE
// before every instruction until step_req is sampled high.
module cpu_control_unit #(
    parameter int                ADDR_W   = 8,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst_n,
`ifdef CPU_SINGLE_STEP_EN
    input  logic              step_req,
`endif
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_ready,
    input  logic [7:0]        mem_rdata,
    output logic [3:0]        alu_op,
    output logic [1:0]        rd_sel,
    output logic [1:0]        rs_sel,
    output logic              reg_we,
    output logic [1:0]        wb_sel,
    output logic [7:0]        imm_out,
    input  logic              zero_flag,
    input  logic              carry_flag,
    input  logic              overflow_flag,
    output logic [2:0]        flags_q,
    output logic [ADDR_W-1:0] pc,
    output logic              halted
);

    localparam logic [3:0] OP_LAST_ALU = 4'h8;
    localparam logic [3:0] OP_LDI      = 4'h9;
    localparam logic [3:0] OP_JMP      = 4'hA;
    localparam logic [3:0] OP_JZ       = 4'hB;
    localparam logic [3:0] OP_JC       = 4'hC;
    localparam logic [3:0] OP_MOV      = 4'hE;
    localparam logic [3:0] OP_HLT      = 4'hF;

    localparam logic [1:0] WB_ALU = 2'd0;
    localparam logic [1:0] WB_IMM = 2'd1;
    localparam logic [1:0] WB_RS  = 2'd2;

    localparam logic [ADDR_W-1:0] PC_ONE = ADDR_W'(1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_FETCH2,
        S_EXECUTE,
        S_HALT
    } state_t;

    state_t            state_reg;
    logic [7:0]        ir_reg;
    logic [7:0]        imm_reg;
    logic [3:0]        opcode;
    logic              two_byte;
    logic              take_jump;
    logic              step_ok;
    logic [ADDR_W-1:0] jump_target;

    assign opcode   = ir_reg[7:4];
    assign rd_sel   = ir_reg[3:2];
    assign rs_sel   = ir_reg[1:0];
    assign imm_out  = imm_reg;
    // The fetch address is the PC itself, so it cannot move while a fetch waits.
    assign mem_addr = pc;

    assign two_byte  = (opcode >= OP_LDI) && (opcode <= OP_JC);
    assign take_jump = (opcode == OP_JMP)
                     || ((opcode == OP_JZ) && flags_q[0])
                     || ((opcode == OP_JC) && flags_q[1]);

`ifdef CPU_SINGLE_STEP_EN
    assign step_ok = step_req;
`else
    assign step_ok = 1'b1;
`endif

    // Jump target: the immediate byte truncated or zero-extended to the PC width.
    generate
        if (ADDR_W > 8) begin : g_pc_wide
            assign jump_target = {{(ADDR_W-8){1'b0}}, imm_reg};
        end else if (ADDR_W == 8) begin : g_pc_byte
            assign jump_target = imm_reg;
        end else begin : g_pc_narrow
            assign jump_target = imm_reg[ADDR_W-1:0];
        end
    endgenerate

    // Sequencer FSM; every output is set on the transition into the state that owns it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= S_IDLE;
            pc        <= RESET_PC;
            ir_reg    <= '0;
            imm_reg   <= '0;
            flags_q   <= '0;
            mem_req   <= 1'b0;
            alu_op    <= '0;
            reg_we    <= 1'b0;
            wb_sel    <= WB_ALU;
            halted    <= 1'b0;
        end else begin
            case (state_reg)
                S_IDLE: begin
                    if (step_ok) begin
                        state_reg <= S_FETCH;
                        mem_req   <= 1'b1;
                    end
                end
                S_FETCH: begin
                    if (mem_ready) begin
                        ir_reg    <= mem_rdata;
                        pc        <= pc + PC_ONE;
                        mem_req   <= 1'b0;
                        state_reg <= S_DECODE;
                    end
                end
                S_DECODE: begin
                    if (two_byte) begin
                        state_reg <= S_FETCH2;
                        mem_req   <= 1'b1;
                    end else begin
                        state_reg <= S_EXECUTE;
                        if (opcode <= OP_LAST_ALU) begin
                            alu_op <= opcode;
                            reg_we <= 1'b1;
                            wb_sel <= WB_ALU;
                        end else if (opcode == OP_MOV) begin
                            reg_we <= 1'b1;
                            wb_sel <= WB_RS;
                        end
                    end
                end
                S_FETCH2: begin
                    if (mem_ready) begin
                        imm_reg   <= mem_rdata;
                        pc        <= pc + PC_ONE;
                        mem_req   <= 1'b0;
                        state_reg <= S_EXECUTE;
                        if (opcode == OP_LDI) begin
                            reg_we <= 1'b1;
                            wb_sel <= WB_IMM;
                        end
                    end
                end
                S_EXECUTE: begin
                    alu_op <= '0;
                    reg_we <= 1'b0;
                    wb_sel <= WB_ALU;
                    if (opcode <= OP_LAST_ALU) begin
                        flags_q <= {overflow_flag, carry_flag, zero_flag};
                    end
                    if (take_jump) begin
                        pc <= jump_target;
                    end
                    if (opcode == OP_HLT) begin
                        state_reg <= S_HALT;
                        halted    <= 1'b1;
                    end else begin
`ifdef CPU_SINGLE_STEP_EN
                        state_reg <= S_IDLE;
`else
                        state_reg <= S_FETCH;
                        mem_req   <= 1'b1;
`endif
                    end
                end
                S_HALT: begin
                    state_reg <= S_HALT;
                end
                default: begin
                    state_reg <= S_IDLE;
                    mem_req   <= 1'b0;
                    alu_op    <= '0;
                    reg_we    <= 1'b0;
                    wb_sel    <= WB_ALU;
                end
            endcase
        end
    end

endmodule

// File: doc/cpu_control_unit.md
Name: cpu_control_unit

Overview:
Multi-cycle instruction sequencer for the 8-bit CPU, sitting directly upstream of the ALU. It fetches instruction bytes from program memory and decodes them. Each cycle it drives alu_op, register-file select and write-enable lines, and it latches the ALU's zero/carry/overflow outputs into a flags register that conditional jumps use. Program-counter (PC) sequencing and halt are also handled here.

Parameters:
ADDR_W, 8, program-counter and memory-address width
RESET_PC, 0, PC value loaded on reset

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
mem_req  output  1  fetch request to program memory
mem_addr  output  ADDR_W  fetch address, equals pc while mem_req=1
mem_ready  input  1  memory data valid; completes the fetch this cycle
mem_rdata  input  8  fetched byte
alu_op  output  4  ALU operation code
rd_sel  output  2  destination / operand-A register index
rs_sel  output  2  source / operand-B register index
reg_we  output  1  register-file write strobe, 1 cycle
wb_sel  output  2  write-back source: 0 ALU result, 1 immediate, 2 register rs
imm_out  output  8  immediate byte for LDI
zero_flag  input  1  from ALU
carry_flag  input  1  from ALU
overflow_flag  input  1  from ALU
flags_q  output  3  latched flags {V,C,Z}
pc  output  ADDR_W  current program counter
halted  output  1  high in HALT state

Behaviour:
- Instruction byte: [7:4] opcode, [3:2] rd, [1:0] rs.
- Opcode map:
  - 0x0–0x8: ALU ops; alu_op = opcode, so ADD, SUB, AND, OR, XOR, NOT, SHL, SHR, CMP.
  - 0x9: LDI rd, #imm (2 bytes).
  - 0xA: JMP addr (2 bytes).
  - 0xB: JZ addr (2 bytes).
  - 0xC: JC addr (2 bytes).
  - 0xD: NOP.
  - 0xE: MOV rd, rs.
  - 0xF: HLT.
- States and transitions:
  - IDLE: entered on reset; goes to FETCH on the next clock.
  - FETCH: mem_req=1, mem_addr=pc. Hold until mem_ready=1. On mem_ready: ir<=mem_rdata, pc<=pc+1, go to DECODE.
  - DECODE: opcodes 0x9–0xC go to FETCH2; all other opcodes go to EXECUTE.
  - FETCH2: mem_req=1, mem_addr=pc. On mem_ready: imm<=mem_rdata, pc<=pc+1, go to EXECUTE.
  - EXECUTE: always one cycle, then back to FETCH, except HLT, which goes to HALT.
  - HALT: terminal; leaves only on reset.
- EXECUTE actions by opcode:
  - ALU ops: alu_op=opcode, rd_sel/rs_sel from ir, reg_we=1, wb_sel=0. flags_q<={overflow_flag,carry_flag,zero_flag} at the end of the cycle.
  - LDI: reg_we=1, wb_sel=1, imm_out=imm.
  - MOV: reg_we=1, wb_sel=2.
  - JMP: pc<=imm.
  - JZ: pc<=imm if flags_q[0]=1.
  - JC: pc<=imm if flags_q[1]=1.
  - NOP and HLT: no register write.
  - flags_q changes only on ALU ops; LDI, MOV and jumps preserve it.
- Outputs outside EXECUTE: reg_we=0, alu_op=0, wb_sel=0.
- mem_req and mem_addr are held stable until mem_ready; mem_ready outside FETCH/FETCH2 is ignored.
- Latency with zero wait states:
  - 1-byte instruction: 3 cycles (FETCH, DECODE, EXECUTE).
  - 2-byte instruction: 4 cycles.
  - Each cycle mem_ready is held low adds one cycle.
- PC is ADDR_W bits and wraps modulo 2^ADDR_W, e.g. 0xFF+1 gives 0x00 for ADDR_W=8. Upper imm bits beyond ADDR_W are ignored; bits are zero-extended when ADDR_W>8.
- Reset (asynchronous, any state, including mid-fetch):
  - state=IDLE, pc=RESET_PC, ir=0, imm=0, flags_q=0.
  - Outputs: mem_req=0, reg_we=0, alu_op=0, wb_sel=0, imm_out=0, halted=0, rd_sel=0, rs_sel=0.

Optional Feature:
- CPU_SINGLE_STEP_EN defined:
  - Adds input step_req (1 bit).
  - The FSM waits in IDLE (and on each EXECUTE→FETCH return, in IDLE) until step_req=1 is sampled, then executes exactly one instruction.
  - step_req held high runs at full speed, with one extra IDLE cycle per instruction.
- Undefined: no step_req port; EXECUTE goes straight to FETCH and IDLE lasts exactly one cycle.

Test Plan:
- Reset release, memory 0x00=0x94 (LDI r1), 0x01=0x5A, mem_ready always 1 -> mem_addr 0x00 then 0x01. In EXECUTE: reg_we=1, wb_sel=1, rd_sel=1, imm_out=0x5A. pc=0x02 after 4 cycles past IDLE.
- ALU instruction 0x16 (SUB r1,r2) with ALU returning zero=1, carry=0, overflow=0 -> alu_op=0001, rd_sel=1, rs_sel=2, reg_we=1 for one cycle, flags_q=3'b001.
- JZ 0x40 following that SUB -> pc=0x40. Repeat with flags_q[0]=0 -> pc continues sequentially at the fall-through address.
- mem_ready held low 3 cycles during FETCH -> mem_req stays 1, mem_addr stays constant, no state advance; the instruction then completes with 3 extra cycles.
- PC at 0xFF executing NOP -> pc wraps to 0x00. HLT (0xF0) -> halted=1, mem_req stays 0 indefinitely.
- rst_n asserted mid-FETCH2 -> outputs immediately at reset values, pc=RESET_PC. After release, fetch restarts at RESET_PC.
